image_ingest: RTL and testbench

Parametrised UART-side frame loader between `uart_receiver` and the frame buffer. It parses a 4-byte big-endian dimension header and converts 1- or 3-channel pixel bytes to 8-bit luma. Each pixel becomes a linear-address buffer write; `frame_done` pulses after the last pixel. It adds dimension checking, an inter-byte timeout and automatic re-arm for back-to-back frames.

---
 rtl/image_ingest_pkg.sv | 28 ++
 rtl/rgb_to_luma.sv | 24 ++
 rtl/image_ingest.sv | 231 +++++++++++++++++++++++
 tb/tb_image_ingest.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ingest_pkg.sv
// ---------------------------------------------------------------------------
// image_ingest_pkg
// Shared definitions for the UART-side frame loader:
//   state_t        parser states (header collection, pixel collection)
//   HDR_LEN        number of dimension header bytes (big-endian W then H)
//   LUMA_W_*       integer luma weights, applied before a right shift
//   LUMA_SHIFT     shift that normalises the weighted sum back to 8 bits
//   ERR_*          encodings driven on err_code
// ---------------------------------------------------------------------------
package image_ingest_pkg;

    typedef enum logic {
        ST_HDR   = 1'b0,
        ST_PIXEL = 1'b1
    } state_t;

    localparam int HDR_LEN = 4;

    localparam logic [15:0] LUMA_W_R   = 16'd77;
    localparam logic [15:0] LUMA_W_G   = 16'd150;
    localparam logic [15:0] LUMA_W_B   = 16'd29;
    localparam int          LUMA_SHIFT = 8;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/rgb_to_luma.sv
// ---------------------------------------------------------------------------
// rgb_to_luma
// Combinational RGB to 8-bit luma conversion:
//   luma = (77*R + 150*G + 29*B) >> 8, truncating, no rounding.
// The weights sum to 256, so the 16-bit sum never overflows (max 65280).
// Ports:
//   r, g, b  in   8  colour components
//   luma     out  8  weighted luma
// ---------------------------------------------------------------------------
module rgb_to_luma
    import image_ingest_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] luma
);

    logic [15:0] sum;

    assign sum  = (LUMA_W_R * {8'd0, r}) + (LUMA_W_G * {8'd0, g}) + (LUMA_W_B * {8'd0, b});
    assign luma = sum[LUMA_SHIFT +: 8];

endmodule

// File: rtl/image_ingest.sv
// ---------------------------------------------------------------------------
// image_ingest
// Frame loader sitting between a UART receiver and a frame buffer. Parses a
// 4-byte big-endian header (width_hi, width_lo, height_hi, height_lo),
// validates it, then turns every CHANNELS-byte pixel into one 8-bit luma
// write at a linear address. Re-arms automatically after each frame and
// aborts a frame whose byte stream stalls for TIMEOUT_CYC cycles.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   rx_data      byte from receiver, qualified by the one-cycle rx_valid
//   width/height accepted dimensions, dim_valid while they hold a good header
//   wr_en/wr_addr/wr_data  one-cycle frame buffer write
//   frame_done   pulse coincident with the final write of a frame
//   busy         high from the first header byte until back in header state
//   err_code     0 none, 1 bad dimensions, 2 timeout (sticky)
// ---------------------------------------------------------------------------
module image_ingest
    import image_ingest_pkg::*;
#(
    parameter int MAX_WIDTH   = 640,
    parameter int MAX_HEIGHT  = 480,
    parameter int CHANNELS    = 3,
    parameter int ADDR_W      = 19,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       width,
    output logic [15:0]       height,
    output logic              dim_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic [1:0]        err_code
);

    localparam int          TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] MAX_W16  = 16'(MAX_WIDTH);
    localparam logic [15:0] MAX_H16  = 16'(MAX_HEIGHT);
    localparam logic [1:0]  HDR_LAST = 2'(HDR_LEN - 1);
    localparam logic [1:0]  CH_LAST  = 2'(CHANNELS - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        hdr_idx;
    logic [7:0]        width_hi;
    logic [7:0]        width_lo;
    logic [7:0]        height_hi;
    logic [1:0]        ch_idx;
    logic [7:0]        ch_r;
    logic [7:0]        ch_g;
    logic [15:0]       col;
    logic [15:0]       row;
    logic [ADDR_W-1:0] addr_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        luma;

    logic [15:0]       hdr_width;
    logic [15:0]       hdr_height;
    logic              dims_ok;
    logic              hdr_byte;
    logic              hdr_accept;
    logic              hdr_reject;
    logic              pix_byte;
    logic              pix_final;
    logic              col_last;
    logic              row_last;
    logic              frame_last;
    logic              timeout_hit;

    // The final header byte is checked straight off the bus, so the
    // assembled height takes its low byte from rx_data.
    assign hdr_width  = {width_hi, width_lo};
    assign hdr_height = {height_hi, rx_data};
    assign dims_ok    = (hdr_width != 16'd0) && (hdr_height != 16'd0) &&
                        (hdr_width <= MAX_W16) && (hdr_height <= MAX_H16);

    assign hdr_byte   = (state == ST_HDR) && rx_valid;
    assign hdr_accept = hdr_byte && (hdr_idx == HDR_LAST) && dims_ok;
    assign hdr_reject = hdr_byte && (hdr_idx == HDR_LAST) && !dims_ok;

    assign pix_byte   = (state == ST_PIXEL) && rx_valid;
    assign pix_final  = pix_byte && (ch_idx == CH_LAST);
    assign col_last   = (col == width - 16'd1);
    assign row_last   = (row == height - 16'd1);
    assign frame_last = pix_final && col_last && row_last;

    // An arriving byte always beats the timeout in the same cycle.
    assign timeout_hit = busy && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    generate
        if (CHANNELS == 3) begin : g_rgb
            rgb_to_luma u_luma (
                .r    (ch_r),
                .g    (ch_g),
                .b    (rx_data),
                .luma (luma)
            );
        end else begin : g_gray
            assign luma = rx_data;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: a good header enters pixel mode; the last pixel
    // or a stalled stream returns to header collection.
    always_comb begin
        state_next = state;
        case (state)
            ST_HDR: begin
                if (hdr_accept) begin
                    state_next = ST_PIXEL;
                end
            end
            ST_PIXEL: begin
                if (frame_last || timeout_hit) begin
                    state_next = ST_HDR;
                end
            end
            default: state_next = ST_HDR;
        endcase
    end

    // Datapath: header assembly, channel holding, pixel counters, write
    // port, timeout counter and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx    <= 2'd0;
            width_hi   <= 8'd0;
            width_lo   <= 8'd0;
            height_hi  <= 8'd0;
            ch_idx     <= 2'd0;
            ch_r       <= 8'd0;
            ch_g       <= 8'd0;
            col        <= 16'd0;
            row        <= 16'd0;
            addr_cnt   <= '0;
            to_cnt     <= '0;
            width      <= 16'd0;
            height     <= 16'd0;
            dim_valid  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (rx_valid) begin
                to_cnt <= '0;
            end else if (busy) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                err_code <= ERR_TIMEOUT;
                busy     <= 1'b0;
                hdr_idx  <= 2'd0;
                ch_idx   <= 2'd0;
                to_cnt   <= '0;
            end else if (hdr_byte) begin
                case (hdr_idx)
                    2'd0: begin
                        width_hi  <= rx_data;
                        dim_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                    2'd1:    width_lo  <= rx_data;
                    2'd2:    height_hi <= rx_data;
                    default: ;
                endcase
                hdr_idx <= (hdr_idx == HDR_LAST) ? 2'd0 : hdr_idx + 2'd1;
                if (hdr_reject) begin
                    err_code <= ERR_DIM;
                    busy     <= 1'b0;
                end
                if (hdr_accept) begin
                    width     <= hdr_width;
                    height    <= hdr_height;
                    dim_valid <= 1'b1;
                    err_code  <= ERR_NONE;
                    col       <= 16'd0;
                    row       <= 16'd0;
                    ch_idx    <= 2'd0;
                    addr_cnt  <= '0;
                end
            end else if (pix_byte) begin
                if (!pix_final) begin
                    if (ch_idx == 2'd0) begin
                        ch_r <= rx_data;
                    end else begin
                        ch_g <= rx_data;
                    end
                    ch_idx <= ch_idx + 2'd1;
                end else begin
                    ch_idx   <= 2'd0;
                    wr_en    <= 1'b1;
                    wr_addr  <= addr_cnt;
                    wr_data  <= luma;
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    if (col_last) begin
                        col <= 16'd0;
                        row <= row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                    if (frame_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_image_ingest.sv
// ---------------------------------------------------------------------------
// tb_image_ingest
// Directed bench for image_ingest. Two instances share clock and reset:
// dut3 (RGB input) and dut1 (grayscale input), both with a short timeout.
// ---------------------------------------------------------------------------
module tb_image_ingest;

    localparam int ADDR_W = 19;

    logic              clk;
    logic              reset;

    logic [7:0]        rx_data3;
    logic              rx_valid3;
    logic [15:0]       width3;
    logic [15:0]       height3;
    logic              dim_valid3;
    logic              wr_en3;
    logic [ADDR_W-1:0] wr_addr3;
    logic [7:0]        wr_data3;
    logic              frame_done3;
    logic              busy3;
    logic [1:0]        err_code3;

    logic [7:0]        rx_data1;
    logic              rx_valid1;
    logic [15:0]       width1;
    logic [15:0]       height1;
    logic              dim_valid1;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [7:0]        wr_data1;
    logic              frame_done1;
    logic              busy1;
    logic [1:0]        err_code1;

    int checks   = 0;
    int failures = 0;
    int fd3_count = 0;

    image_ingest #(
        .MAX_WIDTH   (640),
        .MAX_HEIGHT  (480),
        .CHANNELS    (3),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (200)
    ) dut3 (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data3),
        .rx_valid   (rx_valid3),
        .width      (width3),
        .height     (height3),
        .dim_valid  (dim_valid3),
        .wr_en      (wr_en3),
        .wr_addr    (wr_addr3),
        .wr_data    (wr_data3),
        .frame_done (frame_done3),
        .busy       (busy3),
        .err_code   (err_code3)
    );

    image_ingest #(
        .MAX_WIDTH   (640),
        .MAX_HEIGHT  (480),
        .CHANNELS    (1),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (200)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid1),
        .width      (width1),
        .height     (height1),
        .dim_valid  (dim_valid1),
        .wr_en      (wr_en1),
        .wr_addr    (wr_addr1),
        .wr_data    (wr_data1),
        .frame_done (frame_done1),
        .busy       (busy1),
        .err_code   (err_code1)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every frame_done pulse of the RGB instance so an aborted frame
    // can be shown not to produce one.
    always @(negedge clk) begin
        if (frame_done3) fd3_count++;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one byte for one clock edge to the selected instance and
    // returns 1 time unit after that edge, where registered outputs are stable.
    task automatic applyStimulus(input bit sel_gray, input logic [7:0] value);
        if (sel_gray) begin
            rx_data1  = value;
            rx_valid1 = 1'b1;
        end else begin
            rx_data3  = value;
            rx_valid3 = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid1 = 1'b0;
        rx_valid3 = 1'b0;
    endtask

    task automatic sendHeader(input bit sel_gray, input logic [15:0] w, input logic [15:0] h);
        applyStimulus(sel_gray, w[15:8]);
        applyStimulus(sel_gray, w[7:0]);
        applyStimulus(sel_gray, h[15:8]);
        applyStimulus(sel_gray, h[7:0]);
    endtask

    task automatic sendPixel3(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        applyStimulus(1'b0, r);
        applyStimulus(1'b0, g);
        applyStimulus(1'b0, b);
    endtask

    logic [7:0] prim_r   [3] = '{8'hFF, 8'h00, 8'h00};
    logic [7:0] prim_g   [3] = '{8'h00, 8'hFF, 8'h00};
    logic [7:0] prim_b   [3] = '{8'h00, 8'h00, 8'hFF};
    logic [7:0] prim_exp [3] = '{8'h4C, 8'h95, 8'h1C};
    logic [7:0] gray_a   [3] = '{8'h0A, 8'h14, 8'h1E};
    logic [7:0] gray_b   [3] = '{8'h01, 8'h02, 8'h03};

    initial begin
        int cnt;
        int fd_before;

        reset     = 1'b1;
        rx_data3  = 8'h00;
        rx_valid3 = 1'b0;
        rx_data1  = 8'h00;
        rx_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_flags", {26'd0, dim_valid3, wr_en3, frame_done3, busy3, err_code3}, 32'd0);
        checkOutput("rst_dims", {width3, height3}, 32'd0);
        checkOutput("rst_write", {5'd0, wr_addr3, wr_data3}, 32'd0);
        reset = 1'b0;

        // White 4x2 frame.
        applyStimulus(1'b0, 8'h00);
        checkOutput("hdr0_busy", {31'd0, busy3}, 32'd1);
        applyStimulus(1'b0, 8'h04);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h02);
        checkOutput("hdr_dim_valid", {31'd0, dim_valid3}, 32'd1);
        checkOutput("hdr_width", {16'd0, width3}, 32'd4);
        checkOutput("hdr_height", {16'd0, height3}, 32'd2);
        for (int p = 0; p < 8; p++) begin
            applyStimulus(1'b0, 8'hFF);
            applyStimulus(1'b0, 8'hFF);
            checkOutput("white_mid_no_wr", {31'd0, wr_en3}, 32'd0);
            applyStimulus(1'b0, 8'hFF);
            checkOutput("white_wr_en", {31'd0, wr_en3}, 32'd1);
            checkOutput("white_addr", {13'd0, wr_addr3}, p);
            checkOutput("white_data", {24'd0, wr_data3}, 32'hFF);
            checkOutput("white_done", {31'd0, frame_done3}, (p == 7) ? 32'd1 : 32'd0);
            checkOutput("white_busy", {31'd0, busy3}, (p == 7) ? 32'd0 : 32'd1);
        end

        // Primary colours, header starting the very next cycle.
        applyStimulus(1'b0, 8'h00);
        checkOutput("nogap_no_wr", {31'd0, wr_en3}, 32'd0);
        checkOutput("nogap_busy", {31'd0, busy3}, 32'd1);
        applyStimulus(1'b0, 8'h03);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h01);
        checkOutput("prim_width", {16'd0, width3}, 32'd3);
        for (int p = 0; p < 3; p++) begin
            sendPixel3(prim_r[p], prim_g[p], prim_b[p]);
            checkOutput("prim_wr_en", {31'd0, wr_en3}, 32'd1);
            checkOutput("prim_addr", {13'd0, wr_addr3}, p);
            checkOutput("prim_data", {24'd0, wr_data3}, {24'd0, prim_exp[p]});
            checkOutput("prim_done", {31'd0, frame_done3}, (p == 2) ? 32'd1 : 32'd0);
        end

        // Oversized width 641 is rejected.
        sendHeader(1'b0, 16'h0281, 16'h0001);
        checkOutput("bad_err", {30'd0, err_code3}, 32'd1);
        checkOutput("bad_dim_valid", {31'd0, dim_valid3}, 32'd0);
        checkOutput("bad_busy", {31'd0, busy3}, 32'd0);
        checkOutput("bad_no_wr", {31'd0, wr_en3}, 32'd0);
        sendHeader(1'b0, 16'h0002, 16'h0001);
        checkOutput("good_err", {30'd0, err_code3}, 32'd0);
        checkOutput("good_dim_valid", {31'd0, dim_valid3}, 32'd1);
        checkOutput("good_width", {16'd0, width3}, 32'd2);

        // Four pixel bytes then silence: timeout after exactly 200 cycles.
        sendPixel3(8'hFF, 8'h00, 8'h00);
        checkOutput("to_first_wr", {31'd0, wr_en3}, 32'd1);
        applyStimulus(1'b0, 8'h12);
        fd_before = fd3_count;
        cnt = 0;
        while (err_code3 != 2'd2 && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("to_cycles", cnt, 32'd200);
        checkOutput("to_err", {30'd0, err_code3}, 32'd2);
        checkOutput("to_no_done", fd3_count, fd_before);
        checkOutput("to_busy", {31'd0, busy3}, 32'd0);
        sendHeader(1'b0, 16'h0001, 16'h0001);
        checkOutput("after_to_err", {30'd0, err_code3}, 32'd0);
        checkOutput("after_to_dims", {width3, height3}, 32'h0001_0001);
        sendPixel3(8'h30, 8'h60, 8'h90);
        checkOutput("mix_data", {24'd0, wr_data3}, 32'h57);
        checkOutput("mix_done", {31'd0, frame_done3}, 32'd1);

        // Reset mid-frame, with a byte presented in the reset cycle.
        sendHeader(1'b0, 16'h0004, 16'h0002);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h10);
        reset     = 1'b1;
        rx_data3  = 8'h05;
        rx_valid3 = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        rx_valid3 = 1'b0;
        checkOutput("mrst_flags", {26'd0, dim_valid3, wr_en3, frame_done3, busy3, err_code3}, 32'd0);
        checkOutput("mrst_dims", {width3, height3}, 32'd0);
        checkOutput("mrst_write", {5'd0, wr_addr3, wr_data3}, 32'd0);
        sendHeader(1'b0, 16'h0001, 16'h0001);
        checkOutput("mrst_hdr_valid", {31'd0, dim_valid3}, 32'd1);
        checkOutput("mrst_hdr_dims", {width3, height3}, 32'h0001_0001);
        sendPixel3(8'h00, 8'h00, 8'hFF);
        checkOutput("mrst_pix", {23'd0, frame_done3, wr_data3}, 32'h11C);

        // Grayscale passthrough, two frames back to back.
        sendHeader(1'b1, 16'h0003, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, gray_a[i]);
            checkOutput("gray_a_wr", {31'd0, wr_en1}, 32'd1);
            checkOutput("gray_a_addr", {13'd0, wr_addr1}, i);
            checkOutput("gray_a_data", {24'd0, wr_data1}, {24'd0, gray_a[i]});
            checkOutput("gray_a_done", {31'd0, frame_done1}, (i == 2) ? 32'd1 : 32'd0);
        end
        sendHeader(1'b1, 16'h0003, 16'h0001);
        checkOutput("gray_b_hdr", {31'd0, dim_valid1}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, gray_b[i]);
            checkOutput("gray_b_addr", {13'd0, wr_addr1}, i);
            checkOutput("gray_b_data", {24'd0, wr_data1}, {24'd0, gray_b[i]});
            checkOutput("gray_b_done", {31'd0, frame_done1}, (i == 2) ? 32'd1 : 32'd0);
        end
        checkOutput("gray_b_busy", {31'd0, busy1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
